mem_arbiter_rr: RTL

Parametrised N-core shared-memory arbiter, the successor to the fixed four-core memory controller. It sits between the GPU cores and a single-port data memory. On an `MRead`/`MWrite` command it serialises one access per clock for every enabled core, in rotating round-robin order. It tolerates a configurable memory read latency, reports per-core read completion, and raises `MReady` when the batch is fully retired.

---
 rtl/mem_arbiter_rr.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Round-robin arbiter that lets N cores share one single-port data memory.
// A read or write command is serialised into one memory access per clock for
// each enabled core, starting from a rotating priority pointer. Read data
// returns through a fixed-latency pipeline tagged with the requesting core.
// MReady is high only when the arbiter is idle and every access has retired.
module mem_arbiter_rr #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        MRead,
  input  logic                        MWrite,
  output logic                        MReady,
  input  logic [N_CORES-1:0]          en,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   data,
  output logic [N_CORES*DATA_W-1:0]   q,
  output logic [N_CORES-1:0]          q_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_rdata
);

  // Width of a core index.
  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Pick the first requesting core at or above ptr, wrapping modulo N_CORES.
  function automatic logic [IW-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                             input logic [IW-1:0]      ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] ci;
    logic          found;
    int            c;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < N_CORES; off++) begin
      c = int'(ptr) + off;
      if (c >= N_CORES) begin
        c = c - N_CORES;
      end
      ci = IW'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        pick  = ci;
      end
    end
    return pick;
  endfunction

  // Index after idx, wrapping back to core 0 after the last core.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    logic [IW-1:0] nxt;
    if (idx == IW'(N_CORES - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IW'(1);
    end
    return nxt;
  endfunction

  // Control state
  state_e                      state_q, state_d;
  logic [N_CORES-1:0]          pending_q, pending_d;
  logic                        op_wr_q, op_wr_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
  logic                        ready_q, ready_d;

  // Registered memory-side outputs
  logic                        wren_q, wren_d;
  logic [ADDR_W-1:0]           maddr_q, maddr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;

  // Registered core-side outputs
  logic [N_CORES*DATA_W-1:0]   rdq_q, rdq_d;
  logic [N_CORES-1:0]          qv_q, qv_d;

  // Read-return pipeline: valid flag and core tag per stage
  logic [RD_LAT-1:0]           pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0][IW-1:0]   pipe_idx_q, pipe_idx_d;

  // Combinational helpers
  logic [IW-1:0]               gnt_idx_s;
  logic [N_CORES-1:0]          gnt_mask_s;
  logic [ADDR_W-1:0]           gnt_addr_s;
  logic [DATA_W-1:0]           gnt_data_s;
  logic                        issue_s;
  logic                        push_s;
  logic                        tail_busy_s;

  assign MReady    = ready_q;
  assign mem_wren  = wren_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign q         = rdq_q;
  assign q_valid   = qv_q;

  // Grant candidate: search the command mask when idle, the leftover set otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      gnt_idx_s = rr_pick(en, rr_ptr_q);
    end else begin
      gnt_idx_s = rr_pick(pending_q, rr_ptr_q);
    end
  end

  // Steer the granted core's address and write data with an AND-OR mux.
  always_comb begin
    gnt_mask_s = '0;
    gnt_addr_s = '0;
    gnt_data_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      gnt_mask_s[i] = (gnt_idx_s == IW'(i));
      gnt_addr_s    = gnt_addr_s | ({ADDR_W{gnt_mask_s[i]}} & addr[i*ADDR_W +: ADDR_W]);
      gnt_data_s    = gnt_data_s | ({DATA_W{gnt_mask_s[i]}} & data[i*DATA_W +: DATA_W]);
    end
  end

  // Any read still in flight behind the stage that retires this cycle.
  always_comb begin
    tail_busy_s = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      tail_busy_s = tail_busy_s | pipe_v_q[i];
    end
  end

  // Next-state for the batch FSM, memory outputs and read returns.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    op_wr_d   = op_wr_q;
    rr_ptr_d  = rr_ptr_q;
    ready_d   = ready_q;
    wren_d    = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    rdq_d     = rdq_q;
    qv_d      = '0;
    issue_s   = 1'b0;
    push_s    = 1'b0;

    // Retire the read leaving the last pipeline stage into its core's register.
    for (int i = 0; i < N_CORES; i++) begin
      if (pipe_v_q[RD_LAT-1] && (pipe_idx_q[RD_LAT-1] == IW'(i))) begin
        rdq_d[i*DATA_W +: DATA_W] = mem_rdata;
        qv_d[i]                   = 1'b1;
      end else begin
        qv_d[i] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if ((MRead || MWrite) && (en != '0)) begin
          // Batch start: first grant goes out on this same edge, and the
          // priority pointer moves just past it so the next batch rotates.
          op_wr_d   = MWrite;
          pending_d = en & ~gnt_mask_s;
          rr_ptr_d  = next_ptr(gnt_idx_s);
          ready_d   = 1'b0;
          issue_s   = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (pending_q != '0) begin
          pending_d = pending_q & ~gnt_mask_s;
          issue_s   = 1'b1;
        end else if (op_wr_q) begin
          // Writes have nothing outstanding once the last one is issued.
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (tail_busy_s) begin
          state_d = S_DRAIN;
        end else begin
          // The final read retires on this edge.
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (tail_busy_s) begin
          state_d = S_DRAIN;
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        pending_d = '0;
        ready_d   = 1'b1;
        state_d   = S_IDLE;
      end
    endcase

    // Drive the memory for the core granted on this edge.
    if (issue_s) begin
      maddr_d = gnt_addr_s;
      if (op_wr_d) begin
        wdata_d = gnt_data_s;
        wren_d  = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      wren_d = 1'b0;
    end
  end

  // Shift the read pipeline one stage and insert the new read tag.
  always_comb begin
    pipe_v_d      = '0;
    pipe_idx_d    = '0;
    pipe_v_d[0]   = push_s;
    pipe_idx_d[0] = gnt_idx_s;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
  end

  // State and output registers; reset abandons any batch in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      op_wr_q    <= 1'b0;
      rr_ptr_q   <= '0;
      ready_q    <= 1'b1;
      wren_q     <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      rdq_q      <= '0;
      qv_q       <= '0;
      pipe_v_q   <= '0;
      pipe_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      op_wr_q    <= op_wr_d;
      rr_ptr_q   <= rr_ptr_d;
      ready_q    <= ready_d;
      wren_q     <= wren_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      rdq_q      <= rdq_d;
      qv_q       <= qv_d;
      pipe_v_q   <= pipe_v_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

endmodule
